router_pkt_tx: RTL and testbench

//  Packet transmitter that drives the router input port (pkt_valid/data/busy/err).

---
 rtl/router_pkt_tx.sv | 174 +++++++++++++++++
 tb/tb_router_pkt_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the router input port: buffers a command's payload, then sends
// header, payload and parity back-to-back and reports the router's parity verdict.
module router_pkt_tx #(
   parameter int unsigned MAX_LEN  = 63,
   parameter int unsigned ERR_WAIT = 3
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_addr,
   input  logic [5:0] cmd_len,
   output logic       cmd_rej,
   input  logic       pl_valid,
   output logic       pl_ready,
   input  logic [7:0] pl_data,
   output logic       pkt_valid,
   output logic [7:0] data_out,
   input  logic       busy,
   input  logic       err,
   output logic       done,
   output logic       done_err
);

   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned CW = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

   typedef enum logic [2:0] {StIdle, StFill, StHdr, StPay, StPar, StChk} state_e;

   state_e          state_q, state_d;
   logic [7:0]      hdr_q, hdr_d;
   logic [7:0]      parity_q, parity_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [AW-1:0]   wr_q, wr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [CW-1:0]   chk_q, chk_d;
   logic            sticky_q, sticky_d;
   logic            cmd_rej_q, cmd_rej_d;
   logic            done_q, done_d;
   logic            done_err_q, done_err_d;
   logic            buf_we;
   logic            cmd_ok;
   logic [7:0]      pl_buf_q [MAX_LEN];

   assign cmd_ok = (cmd_addr != 2'd3) && (cmd_len != 6'd0) && (32'(cmd_len) <= MAX_LEN);

   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      parity_d   = parity_q;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      chk_d      = chk_q;
      sticky_d   = sticky_q;
      cmd_rej_d  = 1'b0;
      done_d     = 1'b0;
      done_err_d = 1'b0;
      buf_we     = 1'b0;
      cmd_ready  = 1'b0;
      pl_ready   = 1'b0;
      pkt_valid  = 1'b0;
      data_out   = 8'h00;

      case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (!cmd_ok) begin
                  cmd_rej_d = 1'b1;
               end else begin
                  hdr_d    = {cmd_len, cmd_addr};
                  parity_d = {cmd_len, cmd_addr};
                  cnt_d    = cmd_len;
                  wr_d     = '0;
                  rd_d     = '0;
                  state_d  = StFill;
               end
            end
         end
         StFill: begin
            pl_ready = 1'b1;
            if (pl_valid) begin
               buf_we   = 1'b1;
               parity_d = parity_q ^ pl_data;
               wr_d     = wr_q + 1'b1;
               cnt_d    = cnt_q - 6'd1;
               if (cnt_q == 6'd1) begin
                  state_d = StHdr;
               end
            end
         end
         StHdr: begin
            pkt_valid = 1'b1;
            data_out  = hdr_q;
            if (!busy) begin
               // Reload the byte count from the header for the transmit pass.
               cnt_d   = hdr_q[7:2];
               state_d = StPay;
            end
         end
         StPay: begin
            pkt_valid = 1'b1;
            data_out  = pl_buf_q[rd_q];
            if (!busy) begin
               rd_d  = rd_q + 1'b1;
               cnt_d = cnt_q - 6'd1;
               if (cnt_q == 6'd1) begin
                  state_d = StPar;
               end
            end
         end
         StPar: begin
            data_out = parity_q;
            if (!busy) begin
               chk_d    = '0;
               sticky_d = 1'b0;
               state_d  = StChk;
            end
         end
         StChk: begin
            if (chk_q == CW'(ERR_WAIT - 1)) begin
               done_d     = 1'b1;
               done_err_d = sticky_q | err;
               state_d    = StIdle;
            end else begin
               chk_d    = chk_q + 1'b1;
               sticky_d = sticky_q | err;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         hdr_q      <= 8'h00;
         parity_q   <= 8'h00;
         cnt_q      <= 6'd0;
         wr_q       <= '0;
         rd_q       <= '0;
         chk_q      <= '0;
         sticky_q   <= 1'b0;
         cmd_rej_q  <= 1'b0;
         done_q     <= 1'b0;
         done_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_q      <= hdr_d;
         parity_q   <= parity_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         chk_q      <= chk_d;
         sticky_q   <= sticky_d;
         cmd_rej_q  <= cmd_rej_d;
         done_q     <= done_d;
         done_err_q <= done_err_d;
      end
   end

   // Payload storage has no reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         pl_buf_q[wr_q] <= pl_data;
      end
   end

   assign cmd_rej  = cmd_rej_q;
   assign done     = done_q;
   assign done_err = done_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: the stimulus side queues expected router beats,
// a negedge monitor checks beats, stalls, gap-free framing and the done/done_err verdict.
module tb_router_pkt_tx;

   localparam int unsigned MAX_LEN  = 63;
   localparam int unsigned ERR_WAIT = 3;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [7:0] b;
      logic       last;
      logic       par;
   } beat_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_addr = 2'd0;
   logic [5:0] cmd_len = 6'd0;
   logic       cmd_rej;
   logic       pl_valid = 1'b0;
   logic       pl_ready;
   logic [7:0] pl_data = 8'h00;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       busy;
   logic       err;
   logic       done;
   logic       done_err;

   logic busy_f = 1'b0, busy_r = 1'b0, err_f = 1'b0, err_r = 1'b0;
   logic busy_rand = 1'b0, err_rand = 1'b0;
   assign busy = busy_f | busy_r;
   assign err  = err_f | err_r;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_rej = 0;
   int got_rej = 0;

   beat_t exp_q[$];
   beat_t mon_e;
   logic  want_par = 1'b0, in_pkt = 1'b0, sticky = 1'b0, done_due = 1'b0, exp_derr = 1'b0;
   int    chk_left = 0;
   logic  prev_hold = 1'b0, prev_pv = 1'b0;
   logic [7:0] prev_do = 8'h00;

   router_pkt_tx #(.MAX_LEN(MAX_LEN), .ERR_WAIT(ERR_WAIT)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .cmd_rej(cmd_rej),
      .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
      .pkt_valid(pkt_valid), .data_out(data_out), .busy(busy), .err(err),
      .done(done), .done_err(done_err)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, req, $time);
      end
   endfunction

   always @(posedge clk) begin
      #1;
      busy_r = busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
      err_r  = err_rand ? ($urandom_range(0, 5) == 0) : 1'b0;
   end

   // Monitor: router-side view of the transmitter.
   always @(negedge clk) begin
      if (!resetn) begin
         exp_q.delete();
         want_par  = 1'b0;
         in_pkt    = 1'b0;
         chk_left  = 0;
         done_due  = 1'b0;
         prev_hold = 1'b0;
      end else begin
         if (done_due) begin
            done_due = 1'b0;
            check("done_pulse", 32'(done), 32'd1);
            check("done_err", 32'(done_err), 32'(exp_derr));
         end else if (done) begin
            check("spurious_done", 32'(done), 32'd0);
         end
         if (cmd_rej) got_rej++;
         if (chk_left > 0) begin
            sticky = sticky | err;
            chk_left--;
            if (chk_left == 0) begin
               done_due = 1'b1;
               exp_derr = sticky;
            end
         end
         if (prev_hold) begin
            check("hold_valid", 32'(pkt_valid), 32'(prev_pv));
            check("hold_data", 32'(data_out), 32'(prev_do));
         end
         if (pkt_valid && !busy) begin
            if (exp_q.size() == 0 || exp_q[0].par) begin
               check("beat_expected", 32'(pkt_valid), 32'd0);
               in_pkt = 1'b0;
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_data", 32'(data_out), 32'(mon_e.b));
               in_pkt   = !mon_e.last;
               want_par = mon_e.last;
            end
         end else if (in_pkt && !pkt_valid) begin
            check("gap_free", 32'(pkt_valid), 32'd1);
            in_pkt = 1'b0;
         end else if (want_par && !pkt_valid && !busy) begin
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("parity", 32'(data_out), 32'(mon_e.b));
            end
            want_par = 1'b0;
            chk_left = ERR_WAIT;
            sticky   = 1'b0;
         end
         prev_hold = busy && (pkt_valid || want_par);
         prev_pv   = pkt_valid;
         prev_do   = data_out;
      end
   end

   function automatic byte_q_t rand_pl(input int n);
      byte_q_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      return q;
   endfunction

   task automatic do_pkt(input logic [1:0] a, input int len, input bit tog, input byte_q_t pl);
      logic [7:0] hdr;
      logic [7:0] par;
      bit         legal;
      bit         hs;
      int         k;
      int         i;
      hdr   = {len[5:0], a};
      par   = hdr;
      legal = (a != 2'd3) && (len > 0) && (len <= int'(MAX_LEN));
      if (legal) begin
         exp_q.push_back('{b: hdr, last: 1'b0, par: 1'b0});
         for (int j = 0; j < len; j++) begin
            par = par ^ pl[j];
            exp_q.push_back('{b: pl[j], last: (j == len - 1), par: 1'b0});
         end
         exp_q.push_back('{b: par, last: 1'b0, par: 1'b1});
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = len[5:0];
      k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) begin
         check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (!legal) begin
         exp_rej++;
         @(negedge clk);
         check("rej_pulse", 32'(cmd_rej), 32'd1);
         check("rej_pl_ready", 32'(pl_ready), 32'd0);
         @(negedge clk);
         check("rej_single", 32'(cmd_rej), 32'd0);
         check("rej_pkt_valid", 32'(pkt_valid), 32'd0);
         check("rej_cmd_ready", 32'(cmd_ready), 32'd1);
         return;
      end
      i = 0;
      k = 0;
      while (i < len && k < 5000) begin
         pl_valid = tog ? 1'($urandom_range(0, 1)) : 1'b1;
         pl_data  = pl[i];
         @(negedge clk);
         hs = pl_valid && pl_ready;
         @(posedge clk);
         #1;
         if (hs) i++;
         k++;
      end
      pl_valid = 1'b0;
      check("fill_count", 32'(i), 32'(len));
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || want_par || chk_left != 0 || done_due || !cmd_ready)
             && k < 3000) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("drain_queue", 32'(exp_q.size()), 32'd0);
      check("drain_idle", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      byte_q_t p;
      int      ln;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_pl_ready", 32'(pl_ready), 32'd0);
      check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_cmd_rej", 32'(cmd_rej), 32'd0);
      check("rst_done", 32'({done, done_err}), 32'd0);
      resetn = 1'b1;

      // Basic packet, no stalls.
      p = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_pkt(2'd1, 4, 1'b0, p);
      wait_drain();

      // Router stalls on the header and mid-payload.
      p = rand_pl(6);
      do_pkt(2'd0, 6, 1'b0, p);
      busy_f = 1'b1;
      repeat (3) @(posedge clk);
      #1 busy_f = 1'b0;
      repeat (2) @(posedge clk);
      #1 busy_f = 1'b1;
      repeat (2) @(posedge clk);
      #1 busy_f = 1'b0;
      wait_drain();

      // Illegal commands.
      p = rand_pl(5);
      do_pkt(2'd3, 5, 1'b0, p);
      do_pkt(2'd0, 0, 1'b0, p);
      do_pkt(2'd3, 0, 1'b0, p);
      repeat (4) @(negedge clk) check("rej_no_pkt", 32'(pkt_valid), 32'd0);

      // err raised in the second check cycle, then a clean packet.
      p = rand_pl(3);
      do_pkt(2'd2, 3, 1'b0, p);
      repeat (3 + 3) @(posedge clk);
      #1 err_f = 1'b1;
      @(posedge clk);
      #1 err_f = 1'b0;
      wait_drain();
      p = rand_pl(2);
      do_pkt(2'd1, 2, 1'b0, p);
      wait_drain();

      // Full-length payload with a toggling upstream.
      p = rand_pl(63);
      do_pkt(2'd2, 63, 1'b1, p);
      wait_drain();

      // Asynchronous reset in the payload phase.
      p = rand_pl(10);
      do_pkt(2'd2, 10, 1'b0, p);
      repeat (4) @(posedge clk);
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("arst_pkt_valid", 32'(pkt_valid), 32'd0);
      check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("arst_data_out", 32'(data_out), 32'd0);
      check("arst_pl_ready", 32'(pl_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      p = rand_pl(5);
      do_pkt(2'd0, 5, 1'b0, p);
      wait_drain();

      // Randomised traffic with router stalls and error noise.
      busy_rand = 1'b1;
      err_rand  = 1'b1;
      for (int n = 0; n < 20; n++) begin
         ln = (n % 5 == 4) ? 0 : int'($urandom_range(1, 63));
         p  = rand_pl(ln);
         do_pkt(2'($urandom_range(0, 3)), ln, 1'($urandom_range(0, 1)), p);
      end
      wait_drain();
      busy_rand = 1'b0;
      err_rand  = 1'b0;
      repeat (3) @(negedge clk);
      check("rej_count", 32'(got_rej), 32'(exp_rej));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
